mpu_sequencer: RTL and testbench



---
 rtl/mpu_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_mpu_sequencer.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_sequencer.sv
// ---------------------------------------------------------------------------
// mpu_sequencer
//
// Fetch/decode/execute sequencer for the MPU core. Owns the program counter,
// fetches instructions over a req/ack instruction-memory port, decodes the
// 3-bit opcode, and issues ALU commands over a valid/ready handshake. Then it
// waits for the ALU completion pulse. Jumps, NOPs and halts are resolved
// internally without involving the ALU.
//
// Opcode map (instruction bits [INSTR_W-1:INSTR_W-3]):
//   000..011  ALU op (ADD, SUB, AND, OR), operand = low ADDR_W bits
//   100       JMP to operand
//   101, 110  NOP (pc + 1)
//   111       HALT
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous, active-low reset
//   i_start        begins execution from pc 0 when idle or halted
//   o_imem_req     instruction fetch request
//   o_imem_addr    fetch address (= pc)
//   i_imem_ack     fetch acknowledge, i_imem_data valid in the same cycle
//   i_imem_data    fetched instruction
//   o_alu_valid    ALU command valid
//   o_alu_op       ALU function: 00 ADD, 01 SUB, 10 AND, 11 OR
//   o_alu_operand  operand field of the current instruction
//   i_alu_ready    ALU accepts command
//   i_alu_done     single-cycle pulse, ALU result written
//   o_pc           current program counter
//   o_busy         high in every state except IDLE and HALT
//   o_halted       high in HALT
//   o_timeout_err  sticky fetch-timeout flag
//
// Optional feature macro: IMEM_TIMEOUT_EN
//   Defined:   a fetch that sees no ack for TIMEOUT consecutive request
//              cycles sets o_timeout_err and halts.
//   Undefined: fetch waits indefinitely and o_timeout_err is tied to 0.
//
// Every output is taken from a register or decoded from the state register,
// so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module mpu_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic               o_alu_valid,
  output logic [1:0]         o_alu_op,
  output logic [ADDR_W-1:0]  o_alu_operand,
  input  logic               i_alu_ready,
  input  logic               i_alu_done,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_busy,
  output logic               o_halted,
  output logic               o_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXEC      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_pc_next;
  logic [INSTR_W-1:0]   r_ir;
  logic [INSTR_W-1:0]   w_ir_next;
  logic                 r_timeout_err;
  logic                 w_timeout_err_next;
  logic [2:0]           w_opcode;
  logic [ADDR_W-1:0]    w_operand;

  assign w_opcode  = r_ir[INSTR_W-1 -: 3];
  assign w_operand = r_ir[ADDR_W-1:0];

`ifdef IMEM_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0]    r_tcnt;
  logic [TCNT_W-1:0]    w_tcnt_next;
`else
  logic                 w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  // State, pc, instruction register and error flag. Reset wins over any
  // handshake in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_ir          <= w_ir_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

`ifdef IMEM_TIMEOUT_EN
  // Fetch-wait counter. It is held at zero outside FETCH, so it is
  // already clear on every entry into FETCH.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= w_tcnt_next;
    end
  end
`endif

  // Next-state logic. Defaults hold every register. A pc of all-ones wraps
  // to zero through the natural ADDR_W-bit addition.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_ir_next          = r_ir;
    w_timeout_err_next = r_timeout_err;
`ifdef IMEM_TIMEOUT_EN
    w_tcnt_next        = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_pc_next    = '0;
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        // An ack in the same cycle the count expires takes priority.
        if (i_imem_ack) begin
          w_ir_next    = i_imem_data;
          w_state_next = S_DECODE;
        end
`ifdef IMEM_TIMEOUT_EN
        else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
          w_timeout_err_next = 1'b1;
          w_state_next       = S_HALT;
        end else begin
          w_tcnt_next = r_tcnt + 1'b1;
        end
`endif
      end
      S_DECODE: begin
        case (w_opcode)
          3'b000, 3'b001, 3'b010, 3'b011: w_state_next = S_EXEC;
          3'b100: begin
            w_pc_next    = w_operand;
            w_state_next = S_FETCH;
          end
          3'b111: w_state_next = S_HALT;
          default: begin
            w_pc_next    = r_pc + 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        if (i_alu_ready) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_alu_done) begin
          w_pc_next    = r_pc + 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_HALT: begin
        if (i_start) begin
          w_pc_next          = '0;
          w_timeout_err_next = 1'b0;
          w_state_next       = S_FETCH;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode. The ALU command fields come straight from the
  // instruction register, which is frozen from DECODE onward, so they are
  // stable for the whole EXEC handshake.
  always_comb begin
    o_imem_req    = (r_state == S_FETCH);
    o_imem_addr   = r_pc;
    o_alu_valid   = (r_state == S_EXEC);
    o_alu_op      = r_ir[INSTR_W-2 -: 2];
    o_alu_operand = w_operand;
    o_pc          = r_pc;
    o_busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    o_halted      = (r_state == S_HALT);
    o_timeout_err = r_timeout_err;
  end

endmodule

// File: tb/tb_mpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mpu_sequencer
//
// Directed testbench for mpu_sequencer. A behavioural instruction memory
// (combinational ack) and an ALU model with programmable ready/done delays
// surround the design. Scenario tasks run in sequence from one initial
// block. Each task drives the stimulus and compares the outputs against
// hand-computed values. The timeout scenario runs only when
// IMEM_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_mpu_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       imem_req;
  logic [4:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       alu_valid;
  logic [1:0] alu_op;
  logic [4:0] alu_operand;
  logic       alu_ready;
  logic       alu_done;
  logic [4:0] pc;
  logic       busy;
  logic       halted;
  logic       timeout_err;

  logic [7:0] mem [32];
  logic       ackEn;

  int tests;
  int failures;
  int cycleCnt;

  // ALU model configuration and logs
  int readyDelay;
  int doneDelay;
  int stallCnt;
  int waitCnt;
  bit pendingDone;
  bit spuriousArm;
  bit prevValid;
  int aluValidLen;
  int aluUnstable;
  int doneCycle;
  int reqCycles;
  logic [1:0] lastOp;
  logic [4:0] lastOperand;
  int fetchAddr[$];
  int fetchCycle[$];
  int aluOpLog[$];
  int aluOperandLog[$];

  mpu_sequencer #(.ADDR_W(5), .INSTR_W(8), .TIMEOUT(15)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .o_imem_req(imem_req),
    .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack),
    .i_imem_data(imem_data),
    .o_alu_valid(alu_valid),
    .o_alu_op(alu_op),
    .o_alu_operand(alu_operand),
    .i_alu_ready(alu_ready),
    .i_alu_done(alu_done),
    .o_pc(pc),
    .o_busy(busy),
    .o_halted(halted),
    .o_timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  assign imem_ack  = imem_req && ackEn;
  assign imem_data = mem[imem_addr];

  // ALU model and activity logger. It runs on the falling edge, and the
  // scenario tasks act 2 time units after the rising edge, so the two
  // never touch shared state at the same instant.
  always @(negedge clk) begin
    if (reqCycles >= 0 && imem_req) reqCycles++;
    if (alu_valid) begin
      aluValidLen++;
      if (!prevValid) begin
        aluOpLog.push_back(int'(alu_op));
        aluOperandLog.push_back(int'(alu_operand));
      end else if (alu_op !== lastOp || alu_operand !== lastOperand) begin
        aluUnstable++;
      end
      lastOp      = alu_op;
      lastOperand = alu_operand;
      alu_ready   = (stallCnt >= readyDelay);
      stallCnt++;
      if (alu_ready) begin
        pendingDone = 1'b1;
        waitCnt     = 0;
      end
      alu_done = 1'b0;
    end else begin
      alu_ready = 1'b0;
      stallCnt  = 0;
      alu_done  = 1'b0;
      if (pendingDone) begin
        if (waitCnt == doneDelay) begin
          alu_done    = 1'b1;
          pendingDone = 1'b0;
          doneCycle   = cycleCnt;
        end else begin
          waitCnt++;
        end
      end else if (spuriousArm && imem_req) begin
        alu_done    = 1'b1;
        spuriousArm = 1'b0;
      end
    end
    if (imem_req && imem_ack) begin
      fetchAddr.push_back(int'(imem_addr));
      fetchCycle.push_back(cycleCnt);
    end
    prevValid = alu_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearLogs();
    fetchAddr.delete();
    fetchCycle.delete();
    aluOpLog.delete();
    aluOperandLog.delete();
    aluValidLen = 0;
    aluUnstable = 0;
    doneCycle   = -1;
    reqCycles   = 0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    tests++;
    if ({imem_req, alu_valid, busy, halted, timeout_err} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {imem_req, alu_valid, busy, halted, timeout_err});
    end
    tests++;
    if ({pc, imem_addr, alu_op, alu_operand} !== 17'b0) begin
      failures++;
      $display("[TB] FAIL reset_buses: pc=%0d addr=%0d op=%0d operand=%0d expected all 0",
               pc, imem_addr, alu_op, alu_operand);
    end
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    tests++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_hold: busy=%b req=%b halted=%b expected 0 0 0",
               busy, imem_req, halted);
    end
  endtask

  task automatic waitHalted(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (!halted) begin
      failures++;
      $display("[TB] FAIL %s_halt_wait: halted=%b after %0d cycles expected 1",
               name, halted, budget);
    end
  endtask

  task automatic test_straight_line();
    int s0;
    clearMem();
    mem[0] = 8'b000_00011;
    mem[1] = 8'b001_00001;
    mem[2] = 8'b111_00000;
    readyDelay = 0;
    doneDelay  = 0;
    clearLogs();
    s0    = cycleCnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitHalted("straight", 40);
    tests++;
    if (pc !== 5'd2 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL straight_pc: pc=%0d busy=%b expected pc=2 busy=0", pc, busy);
    end
    tests++;
    if (fetchCycle.size() < 1 || fetchCycle[0] - s0 != 1) begin
      failures++;
      $display("[TB] FAIL straight_start_latency: got %0d expected 1",
               (fetchCycle.size() > 0) ? fetchCycle[0] - s0 : -1);
    end
    tests++;
    if (aluOpLog.size() != 2) begin
      failures++;
      $display("[TB] FAIL straight_alu_count: got %0d expected 2", aluOpLog.size());
    end else begin
      tests++;
      if (aluOpLog[0] != 0 || aluOperandLog[0] != 3) begin
        failures++;
        $display("[TB] FAIL straight_add: op=%0d operand=%0d expected op=0 operand=3",
                 aluOpLog[0], aluOperandLog[0]);
      end
      tests++;
      if (aluOpLog[1] != 1 || aluOperandLog[1] != 1) begin
        failures++;
        $display("[TB] FAIL straight_sub: op=%0d operand=%0d expected op=1 operand=1",
                 aluOpLog[1], aluOperandLog[1]);
      end
    end
    tests++;
    if (fetchCycle.size() != 3 || fetchCycle[1] - fetchCycle[0] != 4) begin
      failures++;
      $display("[TB] FAIL straight_issue_spacing: fetches=%0d spacing=%0d expected 3 and 4",
               fetchCycle.size(),
               (fetchCycle.size() > 1) ? fetchCycle[1] - fetchCycle[0] : -1);
    end
  endtask

  task automatic test_jump_nop();
    int n;
    int expAddr[4];
    int expGap[3];
    expAddr = '{0, 30, 31, 0};
    expGap  = '{2, 2, 4};
    clearMem();
    mem[0]  = 8'b100_11110;
    mem[30] = 8'b101_00000;
    mem[31] = 8'b010_00111;
    clearLogs();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (fetchAddr.size() < 4 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (fetchAddr.size() < 4) begin
      failures++;
      $display("[TB] FAIL jump_fetch_wait: got %0d fetches expected 4", fetchAddr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (fetchAddr[i] != expAddr[i]) begin
          failures++;
          $display("[TB] FAIL jump_fetch_addr[%0d]: got %0d expected %0d",
                   i, fetchAddr[i], expAddr[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (fetchCycle[i+1] - fetchCycle[i] != expGap[i]) begin
          failures++;
          $display("[TB] FAIL jump_gap[%0d]: got %0d expected %0d",
                   i, fetchCycle[i+1] - fetchCycle[i], expGap[i]);
        end
      end
    end
    tests++;
    if (aluOpLog.size() < 1 || aluOpLog[0] != 2 || aluOperandLog[0] != 7) begin
      failures++;
      $display("[TB] FAIL jump_and_issue: count=%0d op=%0d operand=%0d expected op=2 operand=7",
               aluOpLog.size(),
               (aluOpLog.size() > 0) ? aluOpLog[0] : -1,
               (aluOperandLog.size() > 0) ? aluOperandLog[0] : -1);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (!alu_valid && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!alu_valid) begin
      failures++;
      $display("[TB] FAIL midreset_exec_wait: alu_valid=%b expected 1", alu_valid);
    end
    rst   = 1'b0;
    start = 1'b1;
    tick();
    tests++;
    if (alu_valid !== 1'b0 || busy !== 1'b0 || pc !== 5'd0 || imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_state: valid=%b busy=%b pc=%0d req=%b expected 0 0 0 0",
               alu_valid, busy, pc, imem_req);
    end
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) tick();
    tests++;
    if (busy !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_idle: busy=%b halted=%b expected 0 0", busy, halted);
    end
  endtask

  task automatic test_handshake_stall();
    int pokes;
    int pcBad;
    clearMem();
    mem[0] = 8'b011_00101;
    mem[1] = 8'b111_00000;
    readyDelay  = 5;
    doneDelay   = 3;
    clearLogs();
    spuriousArm = 1'b1;
    pokes = 0;
    pcBad = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60 && !halted; i++) begin
      if (alu_valid && pc !== 5'd0) pcBad++;
      if (alu_valid && pokes < 2) begin
        start = 1'b1;
        pokes++;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    tests++;
    if (!halted || pc !== 5'd1) begin
      failures++;
      $display("[TB] FAIL stall_halt: halted=%b pc=%0d expected 1 and pc=1", halted, pc);
    end
    tests++;
    if (aluValidLen != 6) begin
      failures++;
      $display("[TB] FAIL stall_valid_len: got %0d expected 6", aluValidLen);
    end
    tests++;
    if (aluUnstable != 0 || pcBad != 0) begin
      failures++;
      $display("[TB] FAIL stall_stable: unstable=%0d pc_changes=%0d expected 0 0",
               aluUnstable, pcBad);
    end
    tests++;
    if (aluOpLog.size() != 1 || aluOpLog[0] != 3 || aluOperandLog[0] != 5) begin
      failures++;
      $display("[TB] FAIL stall_or_issue: count=%0d expected one OR with operand 5",
               aluOpLog.size());
    end
    tests++;
    if (fetchAddr.size() != 2 || fetchAddr[1] != 1 || fetchCycle[1] != doneCycle + 1) begin
      failures++;
      $display("[TB] FAIL stall_refetch: fetches=%0d cycle=%0d expected 2 fetches, second at %0d",
               fetchAddr.size(),
               (fetchCycle.size() > 1) ? fetchCycle[1] : -1, doneCycle + 1);
    end
  endtask

`ifdef IMEM_TIMEOUT_EN
  task automatic test_timeout();
    clearLogs();
    ackEn = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitHalted("timeout", 40);
    tests++;
    if (reqCycles != 15) begin
      failures++;
      $display("[TB] FAIL timeout_req_cycles: got %0d expected 15", reqCycles);
    end
    tests++;
    if (timeout_err !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_flag: err=%b req=%b busy=%b expected 1 0 0",
               timeout_err, imem_req, busy);
    end
    clearMem();
    mem[0] = 8'b111_00000;
    ackEn  = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tests++;
    if (timeout_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 5'd0) begin
      failures++;
      $display("[TB] FAIL timeout_restart: err=%b req=%b addr=%0d expected 0 1 0",
               timeout_err, imem_req, imem_addr);
    end
    waitHalted("timeout_restart", 10);
  endtask
`endif

  initial begin
    tests       = 0;
    failures    = 0;
    cycleCnt    = 0;
    ackEn       = 1'b1;
    rst         = 1'b0;
    start       = 1'b0;
    alu_ready   = 1'b0;
    alu_done    = 1'b0;
    readyDelay  = 0;
    doneDelay   = 0;
    stallCnt    = 0;
    waitCnt     = 0;
    pendingDone = 1'b0;
    spuriousArm = 1'b0;
    prevValid   = 1'b0;
    lastOp      = '0;
    lastOperand = '0;
    clearMem();
    clearLogs();
    test_reset();
    test_straight_line();
    test_jump_nop();
    test_mid_reset();
    test_handshake_stall();
`ifdef IMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
